// File: rtl/alu_pkg.sv
// Shared definitions for the execute/write-back slice: ALU opcodes,
// default widths and write-back select encodings.
package alu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 4;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_NOR   = 4'b0101;
  localparam logic [3:0] ALU_SLL   = 4'b0110;
  localparam logic [3:0] ALU_SRL   = 4'b0111;
  localparam logic [3:0] ALU_SRA   = 4'b1000;
  localparam logic [3:0] ALU_SLT   = 4'b1001;
  localparam logic [3:0] ALU_SLTU  = 4'b1010;
  localparam logic [3:0] ALU_PASSB = 4'b1011;

  // Destination register select and write data select share the same 0/1 sense
  localparam logic SEL_AR  = 1'b0;
  localparam logic SEL_T   = 1'b1;
  localparam logic SEL_ALU = 1'b0;
  localparam logic SEL_IMM = 1'b1;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: result and carry from two operands and a 4-bit op.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              cout
);

  localparam int SH_W = $clog2(DATA_W);

  logic [DATA_W:0]    add_sum;
  logic [DATA_W:0]    sub_sum;
  logic [SH_W-1:0]    shamt;
  logic [DATA_W-1:0]  one;

  assign one     = {{(DATA_W-1){1'b0}}, 1'b1};
  assign add_sum = {1'b0, a} + {1'b0, b};
  // Subtraction as A + ~B + 1 so the carry out means "no borrow"
  assign sub_sum = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
  assign shamt   = b[SH_W-1:0];

  always_comb begin
    result = '0;
    cout   = 1'b0;
    case (op)
      ALU_ADD: begin
        result = add_sum[DATA_W-1:0];
        cout   = add_sum[DATA_W];
      end
      ALU_SUB: begin
        result = sub_sum[DATA_W-1:0];
        cout   = sub_sum[DATA_W];
      end
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_NOR:   result = ~(a | b);
      ALU_SLL:   result = a << shamt;
      ALU_SRL:   result = a >> shamt;
      ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
      ALU_SLT:   result = ($signed(a) < $signed(b)) ? one : '0;
      ALU_SLTU:  result = (a < b) ? one : '0;
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/alu_writeback_stage.sv
// Execute/write-back slice: ALU, destination and data selectors, and one
// enabled register stage feeding the register file.
module alu_writeback_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              en,
  input  logic [DATA_W-1:0] alu_inputA,
  input  logic [DATA_W-1:0] alu_inputB,
  input  logic [3:0]        alu_control,
  input  logic [REG_AW-1:0] rd_ar,
  input  logic [REG_AW-1:0] rd_t,
  input  logic [DATA_W-1:0] imm_ext,
  input  logic              C_ART_reg,
  input  logic              C_ART_data,
  output logic [DATA_W-1:0] alu_output,
  output logic              alu_cout,
  output logic              zero,
  output logic [REG_AW-1:0] writeReg,
  output logic [DATA_W-1:0] writeData
);

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic [REG_AW-1:0] reg_sel;
  logic [DATA_W-1:0] data_sel;
  logic              result_zero;

  alu_core #(
    .DATA_W (DATA_W)
  ) u_alu_core (
    .a      (alu_inputA),
    .b      (alu_inputB),
    .op     (alu_control),
    .result (alu_result),
    .cout   (alu_carry)
  );

  assign reg_sel     = (C_ART_reg == SEL_T) ? rd_t : rd_ar;
  assign data_sel    = (C_ART_data == SEL_IMM) ? imm_ext : alu_result;
  // Zero flag follows the ALU result, not the selected write data
  assign result_zero = (alu_result == '0);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      alu_output <= '0;
      alu_cout   <= 1'b0;
      zero       <= 1'b0;
      writeReg   <= '0;
      writeData  <= '0;
    end else if (en) begin
      alu_output <= alu_result;
      alu_cout   <= alu_carry;
      zero       <= result_zero;
      writeReg   <= reg_sel;
      writeData  <= data_sel;
    end
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed self-checking bench for alu_writeback_stage.
module tb_alu_writeback_stage;

  logic        CLK;
  logic        RESET;
  logic        en;
  logic [31:0] alu_inputA;
  logic [31:0] alu_inputB;
  logic [3:0]  alu_control;
  logic [3:0]  rd_ar;
  logic [3:0]  rd_t;
  logic [31:0] imm_ext;
  logic        C_ART_reg;
  logic        C_ART_data;
  logic [31:0] alu_output;
  logic        alu_cout;
  logic        zero;
  logic [3:0]  writeReg;
  logic [31:0] writeData;

  int checks = 0;
  int errors = 0;

  alu_writeback_stage dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .en          (en),
    .alu_inputA  (alu_inputA),
    .alu_inputB  (alu_inputB),
    .alu_control (alu_control),
    .rd_ar       (rd_ar),
    .rd_t        (rd_t),
    .imm_ext     (imm_ext),
    .C_ART_reg   (C_ART_reg),
    .C_ART_data  (C_ART_data),
    .alu_output  (alu_output),
    .alu_cout    (alu_cout),
    .zero        (zero),
    .writeReg    (writeReg),
    .writeData   (writeData)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // drivers
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       input logic [3:0] ar, input logic [3:0] t, input logic [31:0] imm,
                       input logic sr, input logic sd);
    alu_inputA  = a;
    alu_inputB  = b;
    alu_control = op;
    rd_ar       = ar;
    rd_t        = t;
    imm_ext     = imm;
    C_ART_reg   = sr;
    C_ART_data  = sd;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    en    = 1'b1;
    drive(32'h1234_5678, 32'h1, 4'b0000, 4'd3, 4'd4, 32'hFFFF_FFFF, 1'b1, 1'b1);
    step();
    step();
    checks++;
    if ({alu_output, alu_cout, zero, writeReg, writeData} !== 70'd0) begin
      errors++;
      $display("FAIL reset_state: got %h %b %b %h %h want all zero",
               alu_output, alu_cout, zero, writeReg, writeData);
    end
    RESET = 1'b1;
  endtask

  task automatic test_add_overflow();
    drive(32'hFFFF_FFFF, 32'h0000_0001, 4'b0000, 4'd5, 4'd7, 32'h0000_1111, 1'b0, 1'b0);
    step();
    checks++;
    if (alu_output !== 32'h0 || alu_cout !== 1'b1 || zero !== 1'b1 ||
        writeReg !== 4'd5 || writeData !== 32'h0) begin
      errors++;
      $display("FAIL add_overflow: got out=%h c=%b z=%b wr=%h wd=%h want 0 1 1 5 0",
               alu_output, alu_cout, zero, writeReg, writeData);
    end
    drive(32'h0000_0003, 32'h0000_0004, 4'b0000, 4'd1, 4'd7, 32'h0, 1'b0, 1'b0);
    step();
    checks++;
    if (alu_output !== 32'h7 || alu_cout !== 1'b0 || zero !== 1'b0 || writeData !== 32'h7) begin
      errors++;
      $display("FAIL add_plain: got out=%h c=%b z=%b wd=%h want 7 0 0 7",
               alu_output, alu_cout, zero, writeData);
    end
  endtask

  task automatic test_sub_compare();
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic [3:0]  vop[5];
    logic [31:0] eo [5];
    logic        ec [5];
    va[0] = 32'd3;          vb[0] = 32'd5; vop[0] = 4'b0001; eo[0] = 32'hFFFF_FFFE; ec[0] = 1'b0;
    va[1] = 32'd5;          vb[1] = 32'd3; vop[1] = 4'b0001; eo[1] = 32'h2;         ec[1] = 1'b1;
    va[2] = 32'd9;          vb[2] = 32'd9; vop[2] = 4'b0001; eo[2] = 32'h0;         ec[2] = 1'b1;
    va[3] = 32'hFFFF_FFFF;  vb[3] = 32'd1; vop[3] = 4'b1001; eo[3] = 32'h1;         ec[3] = 1'b0;
    va[4] = 32'hFFFF_FFFF;  vb[4] = 32'd1; vop[4] = 4'b1010; eo[4] = 32'h0;         ec[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(va[i], vb[i], vop[i], 4'd2, 4'd3, 32'h0, 1'b0, 1'b0);
      step();
      checks++;
      if (alu_output !== eo[i] || alu_cout !== ec[i] || zero !== (eo[i] == 32'h0)) begin
        errors++;
        $display("FAIL sub_compare[%0d]: got out=%h c=%b z=%b want out=%h c=%b z=%b",
                 i, alu_output, alu_cout, zero, eo[i], ec[i], eo[i] == 32'h0);
      end
    end
  endtask

  task automatic test_logic_ops();
    logic [3:0]  vop[5];
    logic [31:0] eo [5];
    vop[0] = 4'b0010; eo[0] = 32'hF000_F000;
    vop[1] = 4'b0011; eo[1] = 32'hFFF0_FFF0;
    vop[2] = 4'b0100; eo[2] = 32'h0FF0_0FF0;
    vop[3] = 4'b0101; eo[3] = 32'h000F_000F;
    vop[4] = 4'b1011; eo[4] = 32'hFF00_FF00;
    for (int i = 0; i < 5; i++) begin
      drive(32'hF0F0_F0F0, 32'hFF00_FF00, vop[i], 4'd6, 4'd8, 32'h0, 1'b0, 1'b0);
      step();
      checks++;
      if (alu_output !== eo[i] || alu_cout !== 1'b0 || writeData !== eo[i]) begin
        errors++;
        $display("FAIL logic_op[%0d]: got out=%h c=%b wd=%h want out=%h c=0",
                 i, alu_output, alu_cout, writeData, eo[i]);
      end
    end
  endtask

  task automatic test_shifts();
    logic [3:0]  vop[3];
    logic [31:0] eo [3];
    vop[0] = 4'b1000; eo[0] = 32'hC000_0000;
    vop[1] = 4'b0111; eo[1] = 32'h4000_0000;
    vop[2] = 4'b0110; eo[2] = 32'h0000_0000;
    for (int i = 0; i < 3; i++) begin
      drive(32'h8000_0000, 32'h0000_0021, vop[i], 4'd1, 4'd2, 32'h0, 1'b0, 1'b0);
      step();
      checks++;
      if (alu_output !== eo[i] || zero !== (eo[i] == 32'h0) || alu_cout !== 1'b0) begin
        errors++;
        $display("FAIL shift[%0d]: got out=%h z=%b c=%b want out=%h",
                 i, alu_output, zero, alu_cout, eo[i]);
      end
    end
  endtask

  task automatic test_t_select();
    drive(32'h1, 32'h1, 4'b0000, 4'd2, 4'd9, 32'hFFFC_0000, 1'b1, 1'b1);
    step();
    checks++;
    if (writeReg !== 4'd9 || writeData !== 32'hFFFC_0000 || alu_output !== 32'h2 || zero !== 1'b0) begin
      errors++;
      $display("FAIL t_select: got wr=%h wd=%h out=%h z=%b want 9 fffc0000 2 0",
               writeReg, writeData, alu_output, zero);
    end
    // Zero follows the ALU result even when imm_ext is written back
    drive(32'h5, 32'h5, 4'b0001, 4'd2, 4'd9, 32'h0000_0042, 1'b0, 1'b1);
    step();
    checks++;
    if (writeReg !== 4'd2 || writeData !== 32'h42 || alu_output !== 32'h0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL imm_zero: got wr=%h wd=%h out=%h z=%b want 2 42 0 1",
               writeReg, writeData, alu_output, zero);
    end
  endtask

  task automatic test_enable_hold();
    drive(32'h10, 32'h20, 4'b0000, 4'd4, 4'd5, 32'h0, 1'b0, 1'b0);
    step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h100 + i, 32'h7, 4'b0100, 4'd11, 4'd12, 32'hABCD_0000, 1'b1, 1'b1);
      step();
      checks++;
      if (alu_output !== 32'h30 || writeReg !== 4'd4 || writeData !== 32'h30 || zero !== 1'b0) begin
        errors++;
        $display("FAIL enable_hold[%0d]: got out=%h wr=%h wd=%h want 30 4 30",
                 i, alu_output, writeReg, writeData);
      end
    end
    en = 1'b1;
    step();
    checks++;
    if (alu_output !== 32'h105 || writeReg !== 4'd12 || writeData !== 32'hABCD_0000) begin
      errors++;
      $display("FAIL enable_resume: got out=%h wr=%h wd=%h want 105 c abcd0000",
               alu_output, writeReg, writeData);
    end
  endtask

  task automatic test_unknown_op();
    drive(32'h5, 32'h7, 4'b1110, 4'd3, 4'd4, 32'h0, 1'b0, 1'b0);
    step();
    checks++;
    if (alu_output !== 32'h0 || zero !== 1'b1 || alu_cout !== 1'b0) begin
      errors++;
      $display("FAIL unknown_op: got out=%h z=%b c=%b want 0 1 0", alu_output, zero, alu_cout);
    end
  endtask

  task automatic test_async_reset();
    drive(32'hFFFF_FFFF, 32'h2, 4'b0000, 4'd7, 4'd8, 32'h0, 1'b0, 1'b0);
    step();
    @(negedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    checks++;
    if ({alu_output, alu_cout, zero, writeReg, writeData} !== 70'd0) begin
      errors++;
      $display("FAIL async_reset: got %h %b %b %h %h want all zero before edge",
               alu_output, alu_cout, zero, writeReg, writeData);
    end
    step();
    en = 1'b0;
    RESET = 1'b1;
    step();
    checks++;
    if ({alu_output, alu_cout, zero, writeReg, writeData} !== 70'd0) begin
      errors++;
      $display("FAIL reset_hold: got %h %b %b %h %h want zero until enabled edge",
               alu_output, alu_cout, zero, writeReg, writeData);
    end
    en = 1'b1;
    step();
    checks++;
    if (alu_output !== 32'h1 || alu_cout !== 1'b1 || writeReg !== 4'd7 || writeData !== 32'h1) begin
      errors++;
      $display("FAIL reset_release: got out=%h c=%b wr=%h wd=%h want 1 1 7 1",
               alu_output, alu_cout, writeReg, writeData);
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_compare();
    test_logic_ops();
    test_shifts();
    test_t_select();
    test_enable_hold();
    test_unknown_op();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_writeback_stage.md
Name: alu_writeback_stage

Overview:
- Execute/write-back slice of the single-cycle processor datapath.
- Combinational 32-bit ALU core followed by two 2:1 write-back selectors:
  - destination register: AR field vs T field;
  - write data: ALU result vs sign-extended constant.
- Results are registered once on CLK for the register file.
- Replaces the separate alu / MUX4_2to1 / MUX32_2to1 trio with one verified unit.

Parameters:
- DATA_W, 32, ALU operand/result and write-data width.
- REG_AW, 4, register-index width.

Ports:
- CLK  input  1  system clock; rising edge.
- RESET  input  1  asynchronous, active-low reset.
- en  input  1  capture enable; outputs update only when en=1.
- alu_inputA  input  DATA_W  operand A (register file read port 1).
- alu_inputB  input  DATA_W  operand B (register file read port 2).
- alu_control  input  4  ALU operation select.
- rd_ar  input  REG_AW  AR-format destination (instr[14:11]).
- rd_t  input  REG_AW  T-format destination (instr[22:19]).
- imm_ext  input  DATA_W  sign-extended 19-bit constant.
- C_ART_reg  input  1  0 = rd_ar, 1 = rd_t.
- C_ART_data  input  1  0 = ALU result, 1 = imm_ext.
- alu_output  output  DATA_W  registered ALU result.
- alu_cout  output  1  registered carry flag.
- zero  output  1  registered (ALU result == 0).
- writeReg  output  REG_AW  registered selected destination.
- writeData  output  DATA_W  registered selected write data.

Behaviour:
- RESET low (asynchronous): alu_output=0, alu_cout=0, zero=0, writeReg=0, writeData=0. Outputs hold 0 until the first enabled edge after release.
- Rising CLK, RESET high, en=1: all outputs load the values computed from the current inputs. Latency is exactly 1 cycle.
- en=0: all outputs hold their previous values.
- ALU ops (A=alu_inputA, B=alu_inputB, unsigned 32-bit arithmetic, wrap-around):
  - 0000 ADD: A+B; cout = carry out of bit 31.
  - 0001 SUB: A+~B+1; cout = carry out (1 = no borrow, i.e. A>=B unsigned).
  - 0010 AND, 0011 OR, 0100 XOR, 0101 NOR: bitwise.
  - 0110 SLL: A<<B[4:0].
  - 0111 SRL: A>>B[4:0], logical.
  - 1000 SRA: A>>>B[4:0], arithmetic.
  - 1001 SLT: signed A<B ? 1 : 0.
  - 1010 SLTU: unsigned A<B ? 1 : 0.
  - 1011 PASSB: B.
  - 1100–1111: result 0.
- cout is 0 for every op other than ADD/SUB.
- zero reflects the ALU result only. It ignores the C_ART_data selection.
- writeReg = C_ART_reg ? rd_t : rd_ar.
- writeData = C_ART_data ? imm_ext : ALU result. The ALU still computes, and alu_output still updates, when imm_ext is selected.
- Shift amount uses only B[4:0]; B[31:5] is ignored.
- No X propagation: unknown alu_control codes yield defined 0.

Decomposition:
- Shared package alu_pkg:
  - 4-bit ALU op localparams (ALU_ADD … ALU_PASSB);
  - DATA_W / REG_AW defaults;
  - select encodings SEL_AR=0, SEL_T=1.
- One natural sub-module, alu_core: purely combinational (A, B, op) -> (result, cout).
- Muxes and output registers stay in the top module.

Test Plan:
- Reset: assert RESET=0 mid-operation with outputs nonzero -> all outputs 0 immediately, without waiting for a clock edge; they stay 0 until the first en=1 edge after release.
- ADD overflow: A=FFFFFFFF, B=00000001, op=0000, sel 0/0, rd_ar=5 -> next cycle alu_output=0, cout=1, zero=1, writeReg=5, writeData=0.
- SUB/compare:
  - A=3, B=5, op=0001 -> FFFFFFFE, cout=0.
  - op=1001 with A=FFFFFFFF, B=1 -> 1.
  - op=1010 with A=FFFFFFFF, B=1 -> 0.
- Shifts: A=80000000, B=00000021 -> SRA gives C0000000 (amount 1), SRL gives 40000000, SLL gives 0.
- T-format select: C_ART_reg=1, C_ART_data=1, rd_t=9, rd_ar=2, imm_ext=FFFC0000, op=ADD (A=1, B=1) -> writeReg=9, writeData=FFFC0000, alu_output=2.
- Enable hold: en=0 while inputs change for 3 cycles -> outputs unchanged; en=1 -> update after one edge. Unknown op 1110 -> alu_output=0, zero=1.
